spi_peripheral: RTL and testbench

Write-only SPI target, SPI mode 0, that owns the five 8-bit control registers consumed by `pwm_peripheral`: output enables, PWM enables and duty cycle. It sits between the `ui_in` pins (SCLK, COPI, nCS) and `pwm_peripheral`. It synchronises the SPI pins into `clk` and decodes fixed 16-bit frames. A register is updated only when a frame completes cleanly.

---
 rtl/spi_regs_pkg.sv | 23 ++
 rtl/sync_ff.sv | 24 ++
 rtl/spi_peripheral.sv | 156 +++++++++++++++
 tb/tb_spi_peripheral.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_regs_pkg.sv
// Shared register map, frame size and SPI target state type.
// Used by spi_peripheral and by the pwm_peripheral bench.
package spi_regs_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } spi_state_t;

    function automatic logic [6:0] frame_addr(input logic [FRAME_BITS-1:0] frame);
        return frame[14:8];
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for one asynchronous input, with a selectable reset level.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI mode-0 target owning the five PWM control registers.
// Define SPI_READBACK_EN to add the cipo read path.
module spi_peripheral
    import spi_regs_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output spi_state_t state
`ifdef SPI_READBACK_EN
    ,
    output logic       cipo
`endif
);

    logic sclk_s, copi_s, ncs_s;
    logic sclk_prev, ncs_prev;
    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

    logic [FRAME_BITS-1:0] shift_reg;
    logic [4:0]            bit_cnt;
    logic                  wr_en;
    logic [6:0]            wr_addr;
    logic [7:0]            wr_data;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s)
    );
    // nCS resets high so a low pin at reset release reads as a falling edge.
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d(ncs), .q(ncs_s)
    );

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ncs_rise  = ncs_s & ~ncs_prev;
    assign ncs_fall  = ~ncs_s & ncs_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b1;
            shift_reg <= '0;
            bit_cnt   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            sclk_prev <= sclk_s;
            ncs_prev  <= ncs_s;
            wr_en     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ncs_fall) begin
                        state     <= ST_SHIFT;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    // A deselect in the same cycle as an SCLK rise drops that bit.
                    if (ncs_rise) begin
                        state <= ST_COMMIT;
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_s};
                        if (bit_cnt != 5'd31) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    state   <= ST_IDLE;
                    wr_addr <= frame_addr(shift_reg);
                    wr_data <= shift_reg[7:0];
                    wr_en   <= (bit_cnt == 5'd16) && shift_reg[15] &&
                               (frame_addr(shift_reg) <= MAX_ADDR);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= wr_data;
                ADDR_EN_OUT_15_8: en_reg_out_15_8 <= wr_data;
                ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= wr_data;
                ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= wr_data;
                ADDR_PWM_DUTY:    pwm_duty_cycle  <= wr_data;
                default: ;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic [7:0] tx_reg;
    logic       tx_active;

    function automatic logic [7:0] read_reg(input logic [6:0] a);
        logic [7:0] v;
        v = '0;
        if (a <= MAX_ADDR) begin
            case (a)
                ADDR_EN_OUT_7_0:  v = en_reg_out_7_0;
                ADDR_EN_OUT_15_8: v = en_reg_out_15_8;
                ADDR_EN_PWM_7_0:  v = en_reg_pwm_7_0;
                ADDR_EN_PWM_15_8: v = en_reg_pwm_15_8;
                ADDR_PWM_DUTY:    v = pwm_duty_cycle;
                default:          v = '0;
            endcase
        end
        return v;
    endfunction

    // The 8th SCLK rise completes the header; the R/W bit sits in shift_reg[6] then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_reg    <= '0;
            tx_active <= 1'b0;
            cipo      <= 1'b0;
        end else if (state != ST_SHIFT || ncs_rise) begin
            tx_reg    <= '0;
            tx_active <= 1'b0;
            cipo      <= 1'b0;
        end else if (sclk_rise && bit_cnt == 5'd7) begin
            tx_active <= ~shift_reg[6];
            tx_reg    <= read_reg({shift_reg[5:0], copi_s});
        end else if (sclk_fall && tx_active) begin
            cipo   <= tx_reg[7];
            tx_reg <= {tx_reg[6:0], 1'b0};
        end
    end
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed vector table, hand-written corner sequences and random frames
// checked against a register-map model of spi_peripheral.
module tb_spi_peripheral;
    import spi_regs_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    spi_state_t state;
    logic       cipo_w;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]  model_regs [5];
    logic [31:0] rx_bits;

    spi_peripheral dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .state(state)
`ifdef SPI_READBACK_EN
        , .cipo(cipo_w)
`endif
    );

`ifndef SPI_READBACK_EN
    assign cipo_w = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] dut_regs();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    // A frame lands only if it is exactly 16 bits, a write, and addresses 0..4.
    function automatic void model_apply(input logic [31:0] bits, input int nbits);
        logic [6:0] a;
        a = bits[14:8];
        if (nbits == 16 && bits[15] && a <= 7'd4) model_regs[a] = bits[7:0];
    endfunction

    function automatic logic [39:0] model_packed();
        return {model_regs[4], model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
    endfunction

    task automatic check_model(input string name);
        check({name, "_out_7_0"},  {56'd0, en_reg_out_7_0},  {56'd0, model_regs[0]});
        check({name, "_out_15_8"}, {56'd0, en_reg_out_15_8}, {56'd0, model_regs[1]});
        check({name, "_pwm_7_0"},  {56'd0, en_reg_pwm_7_0},  {56'd0, model_regs[2]});
        check({name, "_pwm_15_8"}, {56'd0, en_reg_pwm_15_8}, {56'd0, model_regs[3]});
        check({name, "_duty"},     {56'd0, pwm_duty_cycle},  {56'd0, model_regs[4]});
    endtask

    task automatic clock_bits(input logic [31:0] bits, input int nbits, input int half);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = bits[i];
            wait_clk(half);
            rx_bits = {rx_bits[30:0], cipo_w};
            sclk = 1'b1;
            wait_clk(half);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [31:0] bits, input int nbits, input int half);
        rx_bits = '0;
        ncs = 1'b0;
        wait_clk(6);
        clock_bits(bits, nbits, half);
        wait_clk(6);
        ncs = 1'b1;
        wait_clk(10);
    endtask

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        logic [39:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{32'h80F0,  16, 40'h00_00_00_00_F0};
        vecs[1] = '{32'h8480,  16, 40'h80_00_00_00_F0};
        vecs[2] = '{32'h82FF,  16, 40'h80_00_FF_00_F0};
        vecs[3] = '{32'h85AA,  16, 40'h80_00_FF_00_F0};
        vecs[4] = '{32'h40AA,  15, 40'h80_00_FF_00_F0};
        vecs[5] = '{32'h10311, 17, 40'h80_00_FF_00_F0};
        vecs[6] = '{32'h0155,  16, 40'h80_00_FF_00_F0};
        vecs[7] = '{32'h8311,  16, 40'h80_11_FF_00_F0};

        for (int i = 0; i < 5; i++) model_regs[i] = 8'h00;
        rx_bits = '0;
        sclk = 1'b0;
        copi = 1'b0;
        ncs  = 1'b1;
        rst_n = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);

        check("reset_regs", {24'd0, dut_regs()}, 64'd0);
        check("reset_state", 64'(state), 64'(ST_IDLE));

        for (int i = 0; i < 8; i++) begin
            spi_frame(vecs[i].bits, vecs[i].nbits, 5);
            model_apply(vecs[i].bits, vecs[i].nbits);
            check($sformatf("vec%0d", i), {24'd0, dut_regs()}, {24'd0, vecs[i].exp});
        end

        // Update latency: first clk edge seeing nCS high plus four.
        ncs = 1'b0;
        wait_clk(6);
        clock_bits(32'h815A, 16, 5);
        wait_clk(6);
        ncs = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("latency_before", {56'd0, en_reg_out_15_8}, 64'h00);
        @(posedge clk);
        #1 check("latency_at", {56'd0, en_reg_out_15_8}, 64'h5A);
        model_apply(32'h815A, 16);
        wait_clk(10);

        // A 17th SCLK rise coinciding with deselect must not count.
        ncs = 1'b0;
        wait_clk(6);
        clock_bits(32'h8277, 16, 5);
        wait_clk(5);
        sclk = 1'b1;
        ncs  = 1'b1;
        wait_clk(5);
        sclk = 1'b0;
        wait_clk(10);
        model_apply(32'h8277, 16);
        check_model("simul_edge");

        // Reset in the middle of a frame, released with nCS still low.
        ncs = 1'b0;
        wait_clk(6);
        clock_bits(32'h81, 8, 5);
        check("midframe_state", 64'(state), 64'(ST_SHIFT));
        rst_n = 1'b0;
        wait_clk(3);
        check("inreset_regs", {24'd0, dut_regs()}, 64'd0);
        check("inreset_state", 64'(state), 64'(ST_IDLE));
        rst_n = 1'b1;
        wait_clk(6);
        clock_bits(32'hC3, 8, 5);
        wait_clk(6);
        ncs = 1'b1;
        wait_clk(10);
        for (int i = 0; i < 5; i++) model_regs[i] = 8'h00;
        check("after_partial", {24'd0, dut_regs()}, 64'd0);
        spi_frame(32'h813C, 16, 5);
        model_apply(32'h813C, 16);
        check("post_reset_write", {56'd0, en_reg_out_15_8}, 64'h3C);
        check_model("post_reset");

        for (int k = 0; k < 20; k++) begin
            logic [15:0] frame;
            logic [31:0] bits;
            int          nb;
            int          sel;
            frame = {1'($urandom_range(0, 3) != 0), 7'($urandom_range(0, 7)), 8'($urandom_range(0, 255))};
            sel = $urandom_range(0, 4);
            if (sel == 0) begin
                nb = 15;
                bits = {17'd0, frame[15:1]};
            end else if (sel == 4) begin
                nb = 17;
                bits = {15'd0, frame, 1'($urandom_range(0, 1))};
            end else begin
                nb = 16;
                bits = {16'd0, frame};
            end
            spi_frame(bits, nb, $urandom_range(4, 6));
            model_apply(bits, nb);
            check($sformatf("rand%0d", k), {24'd0, dut_regs()}, {24'd0, model_packed()});
        end

`ifdef SPI_READBACK_EN
        spi_frame(32'h83A5, 16, 5);
        model_apply(32'h83A5, 16);
        spi_frame(32'h0300, 16, 5);
        check("read_header_cipo", {56'd0, rx_bits[15:8]}, 64'h00);
        check("read_data_cipo", {56'd0, rx_bits[7:0]}, 64'hA5);
        check("read_keeps_reg", {56'd0, en_reg_pwm_15_8}, 64'hA5);
        spi_frame(32'h0700, 16, 5);
        check("read_oor_cipo", {56'd0, rx_bits[7:0]}, 64'h00);
`endif
        check_model("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
